// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and parity mode constants shared by RX and TX blocks
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT} rx_state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO with occupancy count and drop pulse
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [AW:0]      count,
  output logic             overrun
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic full, do_push, do_pop;
  assign valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd];
  // storage only; unread slots are masked downstream so no reset is needed
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  // pointers wrap naturally at the power-of-two depth; a refused push raises a one-cycle overrun
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      overrun <= 1'b0;
    end else begin
      wr <= do_push ? wr + AW'(1) : wr;
      rd <= do_pop ? rd + AW'(1) : rd;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      overrun <= push & ~do_push;
    end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: mid-bit sampling UART receiver with configurable framing and a receive FIFO
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         uart_rx,
  input  logic [DIV_W-1:0]             baud_div,
  output logic [7:0]                   data_rx,
  output logic                         uart_valid,
  input  logic                         uart_ready,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         overrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  logic [1:0] sync;
  logic rx_s, tick, last_bit, perr, push, valid;
  rx_state_t state, state_n;
  logic [DIV_W-1:0] cnt, div_q;
  logic [DATA_BITS-1:0] sh;
  logic [2:0] idx;
  logic [9:0] push_word, head;
  assign rx_s = sync[1];
  assign tick = cnt == '0;
  assign last_bit = idx == 3'(DATA_BITS-1);
  // two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else sync <= {sync[0], uart_rx};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  // frame sequencing: each timed state advances only on a counter event
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:       if (!rx_s) state_n = S_START;
      S_START:      if (tick) state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA:       if (tick && last_bit) state_n = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
      S_PARITY:     if (tick) state_n = S_STOP;
      S_STOP:       if (tick) state_n = rx_s ? S_IDLE : S_BREAK_WAIT;
      S_BREAK_WAIT: if (rx_s) state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
  end
  // the completed byte is pushed on the stop-bit sample, a low stop marks a framing error
  always_comb begin
    push = state == S_STOP && tick;
    push_word = {8'(sh), ~rx_s, perr};
  end
  // bit timer, divider latch, LSB-first shifter and parity check
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      div_q <= '0;
      sh <= '0;
      idx <= '0;
      perr <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (!rx_s) begin
          div_q <= baud_div;
          cnt <= baud_div >> 1;
          idx <= '0;
          perr <= 1'b0;
        end
      end else if (state != S_BREAK_WAIT) cnt <= tick ? div_q : cnt - DIV_W'(1);
      if (state == S_DATA && tick) begin
        sh <= {rx_s, sh[DATA_BITS-1:1]};
        idx <= idx + 3'd1;
      end
      if (state == S_PARITY && tick) perr <= (PARITY == PARITY_EVEN) ? ^{sh, rx_s} : ~^{sh, rx_s};
    end
  uart_rx_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(push_word),
    .pop(uart_ready),
    .dout(head),
    .valid(valid),
    .count(fifo_count),
    .overrun(overrun)
  );
  assign uart_valid = valid;
  assign data_rx = valid ? head[9:2] : '0;
  assign frame_err = valid & head[1];
  assign parity_err = valid & head[0];
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: three receiver configurations checked against a frame-level scoreboard
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] line = '1;
  logic [2:0] rdy = '0;
  logic [2:0] valid, fe, pe, ovr;
  logic [11:0] bd [3] = '{12'd15, 12'd15, 12'd15};
  logic [7:0] dat [3];
  logic [2:0] fc0;
  logic [3:0] fc1;
  logic [1:0] fc2;
  int rmode [3] = '{0, 0, 0};
  int vcyc [3] = '{0, 0, 0};
  int pops [3] = '{0, 0, 0};
  int ovr_cnt [3] = '{0, 0, 0};
  int exp_ovr [3] = '{0, 0, 0};
  logic [9:0] last_pop [3] = '{10'd0, 10'd0, 10'd0};
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  logic [9:0] q2 [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_param u0 (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[0]), .baud_div(bd[0]), .data_rx(dat[0]),
    .uart_valid(valid[0]), .uart_ready(rdy[0]), .frame_err(fe[0]), .parity_err(pe[0]),
    .overrun(ovr[0]), .fifo_count(fc0)
  );
  uart_rx_param #(.PARITY(1), .FIFO_DEPTH(8)) u1 (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[1]), .baud_div(bd[1]), .data_rx(dat[1]),
    .uart_valid(valid[1]), .uart_ready(rdy[1]), .frame_err(fe[1]), .parity_err(pe[1]),
    .overrun(ovr[1]), .fifo_count(fc1)
  );
  uart_rx_param #(.DATA_BITS(5), .PARITY(2), .FIFO_DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[2]), .baud_div(bd[2]), .data_rx(dat[2]),
    .uart_valid(valid[2]), .uart_ready(rdy[2]), .frame_err(fe[2]), .parity_err(pe[2]),
    .overrun(ovr[2]), .fifo_count(fc2)
  );

  function automatic int dep(input int u);
    return u == 0 ? 4 : u == 1 ? 8 : 2;
  endfunction

  function automatic int fcnt(input int u);
    return u == 0 ? int'(fc0) : u == 1 ? int'(fc1) : int'(fc2);
  endfunction

  function automatic int qsz(input int u);
    return u == 0 ? q0.size() : u == 1 ? q1.size() : q2.size();
  endfunction

  function automatic logic [9:0] qfront(input int u);
    return u == 0 ? q0[0] : u == 1 ? q1[0] : q2[0];
  endfunction

  task automatic qpush(input int u, input logic [9:0] v);
    if (u == 0) q0.push_back(v);
    else if (u == 1) q1.push_back(v);
    else q2.push_back(v);
  endtask

  task automatic qpop(input int u);
    if (u == 0) void'(q0.pop_front());
    else if (u == 1) void'(q1.pop_front());
    else void'(q2.pop_front());
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // consumer handshake: held low, held high, or random per receiver
  always @(posedge clk) begin
    #2;
    for (int u = 0; u < 3; u++)
      rdy[u] = rmode[u] == 2 ? 1'($urandom_range(0, 1)) : (rmode[u] == 1);
  end

  task automatic cmp(input int u);
    logic [9:0] h;
    h = {dat[u], fe[u], pe[u]};
    check($sformatf("dut%0d_count_bound", u), 32'(fcnt(u) <= dep(u)), 32'd1);
    check($sformatf("dut%0d_valid_vs_count", u), 32'(valid[u]), 32'(fcnt(u) != 0));
    if (!valid[u]) check($sformatf("dut%0d_empty_zero", u), 32'(h), 32'd0);
    else if (qsz(u) == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_unexpected_entry: got 0x%0h, want no entry", u, h);
    end else begin
      check($sformatf("dut%0d_head", u), 32'(h), 32'(qfront(u)));
      if (rdy[u]) begin
        qpop(u);
        last_pop[u] = h;
        pops[u]++;
      end
    end
    if (ovr[u]) ovr_cnt[u]++;
    if (valid[u]) vcyc[u]++;
  endtask

  // per-cycle comparison of every receiver against the scoreboard
  always @(negedge clk)
    if (rst_n)
      for (int u = 0; u < 3; u++) cmp(u);

  // drives one frame; the expected entry follows from what the bench deliberately sent
  task automatic send(input int u, input logic [7:0] data, input bit pbad, input bit stop,
                      input int div, input int hold);
    int nb, pm, n;
    logic [11:0] fr;
    logic [7:0] d;
    bit pb;
    nb = u == 2 ? 5 : 8;
    pm = u == 1 ? 1 : u == 2 ? 2 : 0;
    d = data & 8'((1 << nb) - 1);
    pb = ^d;
    if (pm == 2) pb = ~pb;
    if (pbad) pb = ~pb;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < nb; i++) fr[1+i] = d[i];
    n = 1 + nb;
    if (pm != 0) begin
      fr[n] = pb;
      n++;
    end
    fr[n] = stop;
    n++;
    if (rmode[u] == 0 && qsz(u) >= dep(u)) exp_ovr[u]++;
    else qpush(u, {d, ~stop, 1'(pm != 0 && pbad)});
    bd[u] = 12'(div);
    for (int k = 0; k < n; k++) begin
      line[u] = fr[k];
      step(div + 1);
      if (k == 0) bd[u] = 12'($urandom_range(2, 40));
    end
    if (!stop) step(hold);
    line[u] = 1'b1;
  endtask

  initial begin
    int p, v;
    step(3);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_overrun", 32'(ovr), 32'd0);
    check("reset_count", 32'(fcnt(0) + fcnt(1) + fcnt(2)), 32'd0);
    check("reset_data0", 32'(dat[0]), 32'd0);
    check("reset_flags", 32'({fe, pe}), 32'd0);
    rst_n = 1'b1;
    step(3);

    rmode[0] = 1;
    vcyc[0] = 0;
    send(0, 8'hA5, 1'b0, 1'b1, 15, 0);
    step(5);
    check("a5_valid_cycles", 32'(vcyc[0]), 32'd1);
    check("a5_popped", 32'(last_pop[0]), 32'h294);

    v = vcyc[0];
    bd[0] = 12'd15;
    line[0] = 1'b0;
    step(5);
    line[0] = 1'b1;
    step(60);
    check("glitch_no_valid", 32'(vcyc[0] - v), 32'd0);
    check("glitch_count", 32'(fc0), 32'd0);

    send(1, 8'h07, 1'b1, 1'b1, 15, 0);
    step(3);
    check("par_bad_data", 32'(dat[1]), 32'h07);
    check("par_bad_flag", 32'(pe[1]), 32'd1);
    rmode[1] = 1;
    step(4);
    rmode[1] = 0;
    send(1, 8'h07, 1'b0, 1'b1, 15, 0);
    step(3);
    check("par_ok_data", 32'(dat[1]), 32'h07);
    check("par_ok_flag", 32'(pe[1]), 32'd0);
    rmode[1] = 1;

    rmode[0] = 0;
    step(3);
    send(0, 8'h3C, 1'b0, 1'b0, 15, 40);
    step(3);
    check("break_frame_err", 32'(fe[0]), 32'd1);
    check("break_data", 32'(dat[0]), 32'h3C);
    check("break_count", 32'(fc0), 32'd1);
    step(200);
    check("break_single_entry", 32'(fc0), 32'd1);
    rmode[0] = 1;
    step(4);
    rmode[0] = 0;
    step(3);

    for (int i = 1; i <= 5; i++) begin
      send(0, 8'(i), 1'b0, 1'b1, 15, 0);
      step(3);
    end
    check("ovr_count_full", 32'(fc0), 32'd4);
    check("ovr_pulses", 32'(ovr_cnt[0]), 32'd1);
    p = pops[0];
    rmode[0] = 1;
    step(10);
    check("ovr_drained", 32'(pops[0] - p), 32'd4);
    check("ovr_last", 32'(last_pop[0]), 32'h010);

    for (int u = 0; u < 3; u++) begin
      rmode[u] = 2;
      for (int f = 0; f < 14; f++) begin
        int w;
        w = 0;
        while (qsz(u) >= dep(u) && w < 3000) begin
          step(1);
          w++;
        end
        if (qsz(u) >= dep(u)) begin
          checks++;
          errors++;
          $display("FAIL dut%0d_drain_timeout: got %0d queued, want below %0d", u, qsz(u), dep(u));
        end
        send(u, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0,
             $urandom_range(6, 20), $urandom_range(0, 30));
        step($urandom_range(3, 8));
      end
    end
    for (int u = 0; u < 3; u++) rmode[u] = 1;
    step(100);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("dut%0d_all_received", u), 32'(qsz(u)), 32'd0);
      check($sformatf("dut%0d_overruns", u), 32'(ovr_cnt[u]), 32'(exp_ovr[u]));
    end

    rmode[2] = 0;
    step(3);
    send(2, 8'h1F, 1'b0, 1'b1, 15, 0);
    step(3);
    check("b5_data", 32'(dat[2]), 32'h1F);
    check("b5_flags", 32'({fe[2], pe[2]}), 32'd0);
    bd[2] = 12'd15;
    line[2] = 1'b0;
    step(16);
    line[2] = 1'b0;
    step(16);
    line[2] = 1'b1;
    step(16);
    line[2] = 1'b0;
    step(8);
    rst_n = 1'b0;
    step(3);
    line[2] = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    check("rst_mid_valid", 32'(valid), 32'd0);
    check("rst_mid_data", 32'(dat[2]), 32'd0);
    rst_n = 1'b1;
    step(2);
    check("post_rst_count", 32'(fcnt(0) + fcnt(1) + fcnt(2)), 32'd0);
    check("post_rst_outputs", 32'({dat[2], fe, pe, ovr}), 32'd0);
    v = vcyc[2];
    step(300);
    check("post_rst_no_frame", 32'(vcyc[2] - v), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
